// File: rtl/hub75_bcm_scan_engine.sv
// HUB75 BCM scan engine: double-buffered framebuffer readout,
// bit-plane shifting overlapped with display, blanked latch/OE.
module hub75_bcm_scan_engine #(
  parameter int LANES = 2,
  parameter int DEPTH = 6,
  parameter int ROW_W = 5,
  parameter int COL_W = 10,
  parameter int BLANK = 4
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        enable,
  input  logic [COL_W-1:0]            pixels_per_row,
  input  logic [11:0]                 bcm_base,
  input  logic                        swap_req,
  output logic                        swap_ack,
  output logic                        buf_sel,
  output logic [ROW_W+COL_W:0]        rd_addr,
  input  logic [LANES*3*DEPTH-1:0]    rd_data,
  output logic                        led_clk,
  output logic                        latch,
  output logic                        oe_n,
  output logic [ROW_W-1:0]            abcde,
  output logic [LANES-1:0]            r,
  output logic [LANES-1:0]            g,
  output logic [LANES-1:0]            b,
  output logic                        frame_sync
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (BLANK > 1) ? $clog2(BLANK) : 1;
  localparam int TW = 12 + DEPTH;
  localparam int DW = 3 * DEPTH;

  typedef enum logic [2:0] {
    S_IDLE, S_SHIFT, S_WAIT, S_BPRE, S_LATCH, S_BPOST
  } state_t;

  state_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [COL_W-1:0] col, col_nxt;
  logic [COL_W-1:0] npix, npix_nxt;
  logic ph, ph_nxt;
  logic [ROW_W-1:0] row, row_nxt, abcde_nxt;
  logic [PW-1:0] plane, plane_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic pend, pend_nxt;
  logic buf_nxt, ack_nxt, led_nxt, frame_end;
  logic [LANES-1:0] r_nxt, g_nxt, b_nxt;
  logic [11:0] base;

  assign base = (bcm_base == 12'd0) ? 12'd1 : bcm_base;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    col_nxt   = col;
    ph_nxt    = ph;
    row_nxt   = row;
    plane_nxt = plane;
    npix_nxt  = npix;
    buf_nxt   = buf_sel;
    pend_nxt  = swap_ack ? 1'b0 : (pend | swap_req);
    ack_nxt   = 1'b0;
    abcde_nxt = abcde;
    led_nxt   = 1'b0;
    r_nxt     = r;
    g_nxt     = g;
    b_nxt     = b;
    timer_nxt = (timer != '0) ? timer - TW'(1) : timer;
    frame_end = (row == {ROW_W{1'b1}}) &&
                (plane == PW'(DEPTH - 1));
    unique case (state)
      S_IDLE: begin
        if (enable) begin
          // a swap held over from idle is taken one clk before shifting
          if ((pend || swap_req) && !swap_ack) begin
            buf_nxt  = ~buf_sel;
            ack_nxt  = 1'b1;
            pend_nxt = 1'b0;
          end else begin
            state_nxt = S_SHIFT;
            npix_nxt  = pixels_per_row;
            row_nxt   = '0;
            plane_nxt = '0;
            col_nxt   = '0;
            ph_nxt    = 1'b0;
          end
        end
      end
      S_SHIFT: begin
        if (npix == '0) begin
          state_nxt = S_WAIT;
        end else if (!ph) begin
          ph_nxt  = 1'b1;
          led_nxt = (col != '0);
        end else begin
          ph_nxt = 1'b0;
          if (col == npix) begin
            state_nxt = S_WAIT;
          end else begin
            col_nxt = col + COL_W'(1);
            for (int l = 0; l < LANES; l++) begin
              r_nxt[l] = rd_data[l*DW + int'(plane)];
              g_nxt[l] = rd_data[l*DW + DEPTH + int'(plane)];
              b_nxt[l] = rd_data[l*DW + 2*DEPTH + int'(plane)];
            end
          end
        end
      end
      S_WAIT: begin
        if (timer == '0) begin
          state_nxt = S_BPRE;
          cnt_nxt   = '0;
        end
      end
      S_BPRE: begin
        if (cnt == CW'(BLANK - 1)) state_nxt = S_LATCH;
        else cnt_nxt = cnt + CW'(1);
      end
      S_LATCH: begin
        state_nxt = S_BPOST;
        cnt_nxt   = '0;
        if (plane == '0) abcde_nxt = row;
      end
      S_BPOST: begin
        if (cnt == CW'(BLANK - 1)) begin
          if (plane == PW'(DEPTH - 1)) begin
            plane_nxt = '0;
            row_nxt   = row + ROW_W'(1);
          end else begin
            plane_nxt = plane + PW'(1);
          end
          if (frame_end) npix_nxt = pixels_per_row;
          if (enable) begin
            state_nxt = S_SHIFT;
            col_nxt   = '0;
            ph_nxt    = 1'b0;
            timer_nxt = TW'(base) << plane;
          end else begin
            state_nxt = S_IDLE;
          end
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    // swap lands in the last post-blank clk of the frame
    if (state_nxt == S_BPOST && cnt_nxt == CW'(BLANK - 1) &&
        frame_end && (pend || swap_req)) begin
      buf_nxt  = ~buf_sel;
      ack_nxt  = 1'b1;
      pend_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= S_IDLE;
      cnt        <= '0;
      col        <= '0;
      ph         <= 1'b0;
      row        <= '0;
      plane      <= '0;
      npix       <= '0;
      timer      <= '0;
      pend       <= 1'b0;
      buf_sel    <= 1'b0;
      swap_ack   <= 1'b0;
      rd_addr    <= '0;
      led_clk    <= 1'b0;
      latch      <= 1'b0;
      oe_n       <= 1'b1;
      abcde      <= '0;
      r          <= '0;
      g          <= '0;
      b          <= '0;
      frame_sync <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      col        <= col_nxt;
      ph         <= ph_nxt;
      row        <= row_nxt;
      plane      <= plane_nxt;
      npix       <= npix_nxt;
      timer      <= timer_nxt;
      pend       <= pend_nxt;
      buf_sel    <= buf_nxt;
      swap_ack   <= ack_nxt;
      if (state_nxt == S_SHIFT)
        rd_addr  <= {buf_nxt, row_nxt, col_nxt};
      led_clk    <= led_nxt;
      latch      <= (state_nxt == S_LATCH);
      oe_n       <= (timer_nxt == '0);
      abcde      <= abcde_nxt;
      r          <= r_nxt;
      g          <= g_nxt;
      b          <= b_nxt;
      frame_sync <= (state_nxt == S_LATCH) &&
                    (row_nxt == '0) && (plane_nxt == '0);
    end
  end

endmodule
